// File: rtl/eva_pkg.sv
// Shared EVA definitions: sequencer state encoding and default counter widths
// used by the update controller and the counter blocks it services.
package eva_pkg;
  localparam int EVA_K       = 3;
  localparam int EVA_CTR_LEN = 10;
  localparam int EVA_ACC_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } eva_state_e;
endpackage

// File: rtl/eva_snap_buf.sv
// N-entry shadow store for the reused-hit, non-reused-hit and eviction counters.
// The whole store loads in one cycle; one entry at a time is read back by index.
module eva_snap_buf #(
  parameter int K       = 3,
  parameter int N       = 2**K,
  parameter int CTR_LEN = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [CTR_LEN*N-1:0]   hits_r_in,
  input  logic [CTR_LEN*N-1:0]   hits_nr_in,
  input  logic [CTR_LEN*N-1:0]   evicts_in,
  input  logic [K-1:0]           rd_idx,
  output logic [CTR_LEN-1:0]     rd_hits_r,
  output logic [CTR_LEN-1:0]     rd_hits_nr,
  output logic [CTR_LEN-1:0]     rd_evicts
);
  logic [CTR_LEN*N-1:0] hits_r_q, hits_r_d;
  logic [CTR_LEN*N-1:0] hits_nr_q, hits_nr_d;
  logic [CTR_LEN*N-1:0] evicts_q, evicts_d;

  always_comb begin
    hits_r_d  = load ? hits_r_in  : hits_r_q;
    hits_nr_d = load ? hits_nr_in : hits_nr_q;
    evicts_d  = load ? evicts_in  : evicts_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_r_q  <= '0;
      hits_nr_q <= '0;
      evicts_q  <= '0;
    end else begin
      hits_r_q  <= hits_r_d;
      hits_nr_q <= hits_nr_d;
      evicts_q  <= evicts_d;
    end
  end

  assign rd_hits_r  = hits_r_q[int'(rd_idx)*CTR_LEN +: CTR_LEN];
  assign rd_hits_nr = hits_nr_q[int'(rd_idx)*CTR_LEN +: CTR_LEN];
  assign rd_evicts  = evicts_q[int'(rd_idx)*CTR_LEN +: CTR_LEN];
endmodule

// File: rtl/eva_update_ctrl.sv
// EVA epoch sequencer: counts accesses, snapshots the counter blocks once per
// epoch, clears them with update_EVA and streams the snapshot out bin by bin.
//   state | meaning
//   IDLE  | waiting for the access interval to elapse
//   SNAP  | shadows load, update_EVA pulses, index set to N-1
//   SCAN  | one bin record per handshake, oldest age first
//   DONE  | epoch finished; restart at once if another epoch is pending
module eva_update_ctrl
  import eva_pkg::*;
#(
  parameter int K       = EVA_K,
  parameter int N       = 2**K,
  parameter int CTR_LEN = EVA_CTR_LEN,
  parameter int ACC_W   = EVA_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 access_valid,
  input  logic [ACC_W-1:0]     interval,
  input  logic [CTR_LEN*N-1:0] hitCtr_R_1D,
  input  logic [CTR_LEN*N-1:0] hitCtr_NR_1D,
  input  logic [CTR_LEN*N-1:0] evictCtr_1D,
  output logic                 update_EVA,
  output logic                 bin_valid,
  input  logic                 bin_ready,
  output logic [K-1:0]         bin_age,
  output logic [CTR_LEN-1:0]   bin_hits_R,
  output logic [CTR_LEN-1:0]   bin_hits_NR,
  output logic [CTR_LEN-1:0]   bin_evicts,
  output logic                 bin_last,
  output logic                 busy,
  output logic                 overrun
);
  eva_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [K-1:0]     index_q, index_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             update_eva_q, update_eva_d;
  logic             bin_valid_q, bin_valid_d;
  logic             busy_q, busy_d;
  logic             trigger;

  // Equality compare only: an interval lowered below acc_cnt waits for the wrap.
  assign trigger = access_valid && (interval != '0) &&
                   (acc_cnt_q == interval - ACC_W'(1));

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (access_valid) acc_cnt_d = trigger ? '0 : acc_cnt_q + ACC_W'(1);

    state_d   = state_q;
    index_d   = index_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    if (trigger && state_q != ST_IDLE) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (trigger) state_d = ST_SNAP;
      ST_SNAP: begin
        index_d = K'(N - 1);
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (bin_ready) begin
          if (index_q == '0) state_d = ST_DONE;
          else               index_d = index_q - K'(1);
        end
      end
      ST_DONE: begin
        if (pending_q || trigger) begin
          pending_d = 1'b0;
          state_d   = ST_SNAP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    update_eva_d = (state_d == ST_SNAP);
    bin_valid_d  = (state_d == ST_SCAN);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      acc_cnt_q    <= '0;
      index_q      <= K'(N - 1);
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      update_eva_q <= 1'b0;
      bin_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      index_q      <= index_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      update_eva_q <= update_eva_d;
      bin_valid_q  <= bin_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Shadows capture on the SNAP edge, the same edge the counter blocks clear.
  eva_snap_buf #(.K(K), .N(N), .CTR_LEN(CTR_LEN)) u_snap_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (state_q == ST_SNAP),
    .hits_r_in  (hitCtr_R_1D),
    .hits_nr_in (hitCtr_NR_1D),
    .evicts_in  (evictCtr_1D),
    .rd_idx     (index_q),
    .rd_hits_r  (bin_hits_R),
    .rd_hits_nr (bin_hits_NR),
    .rd_evicts  (bin_evicts)
  );

  assign update_EVA = update_eva_q;
  assign bin_valid  = bin_valid_q;
  assign bin_age    = index_q;
  assign bin_last   = bin_valid_q && (index_q == '0);
  assign busy       = busy_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_eva_update_ctrl.sv
// Directed bench for eva_update_ctrl: epoch trigger, record stream, stalls,
// back-to-back epochs, overrun and mid-scan reset.
module tb_eva_update_ctrl;
  localparam int K       = 3;
  localparam int N       = 8;
  localparam int CTR_LEN = 10;
  localparam int ACC_W   = 13;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 access_valid;
  logic [ACC_W-1:0]     interval;
  logic [CTR_LEN*N-1:0] hitCtr_R_1D, hitCtr_NR_1D, evictCtr_1D;
  logic                 update_EVA, bin_valid, bin_ready, bin_last, busy, overrun;
  logic [K-1:0]         bin_age;
  logic [CTR_LEN-1:0]   bin_hits_R, bin_hits_NR, bin_evicts;

  logic [CTR_LEN-1:0] exp_r [N];
  logic [CTR_LEN-1:0] exp_nr[N];
  logic [CTR_LEN-1:0] exp_ev[N];

  int n_tests = 0;
  int n_fail  = 0;

  eva_update_ctrl #(.K(K), .N(N), .CTR_LEN(CTR_LEN), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .access_valid (access_valid),
    .interval     (interval),
    .hitCtr_R_1D  (hitCtr_R_1D),
    .hitCtr_NR_1D (hitCtr_NR_1D),
    .evictCtr_1D  (evictCtr_1D),
    .update_EVA   (update_EVA),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .bin_age      (bin_age),
    .bin_hits_R   (bin_hits_R),
    .bin_hits_NR  (bin_hits_NR),
    .bin_evicts   (bin_evicts),
    .bin_last     (bin_last),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_inputs(input int seed);
    for (int w = 0; w < N; w++) begin
      exp_r[w]  = CTR_LEN'(seed + w * 11);
      exp_nr[w] = CTR_LEN'(seed * 3 + w * 37 + 100);
      exp_ev[w] = CTR_LEN'(seed + w * 5 + 200);
    end
    if (seed == 0) begin
      exp_r[3]  = 10'd5;
      exp_ev[0] = 10'd7;
    end
    for (int w = 0; w < N; w++) begin
      hitCtr_R_1D[w*CTR_LEN +: CTR_LEN]  = exp_r[w];
      hitCtr_NR_1D[w*CTR_LEN +: CTR_LEN] = exp_nr[w];
      evictCtr_1D[w*CTR_LEN +: CTR_LEN]  = exp_ev[w];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the SNAP cycle.
  task automatic start_epoch(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_before_trigger", busy, 1'b0);
      access_valid = 1'b1;
      cyc();
    end
    access_valid = 1'b0;
    chk("snap_update_EVA", update_EVA, 1'b1);
    chk("snap_busy", busy, 1'b1);
    chk("snap_bin_valid", bin_valid, 1'b0);
  endtask

  task automatic check_rec(input int a);
    chk("rec_valid", bin_valid, 1'b1);
    chk("rec_age", bin_age, a);
    chk("rec_hits_R", bin_hits_R, exp_r[a]);
    chk("rec_hits_NR", bin_hits_NR, exp_nr[a]);
    chk("rec_evicts", bin_evicts, exp_ev[a]);
    chk("rec_last", bin_last, a == 0);
    chk("rec_no_update", update_EVA, 1'b0);
  endtask

  // Called at the SNAP negedge; returns at the DONE negedge.
  task automatic run_scan(input int stall_age, input logic [N-1:0] acc_mask, input bit scramble);
    cyc();
    if (scramble) begin
      hitCtr_R_1D  = ~hitCtr_R_1D;
      hitCtr_NR_1D = ~hitCtr_NR_1D;
      evictCtr_1D  = ~evictCtr_1D;
    end
    for (int a = N - 1; a >= 0; a--) begin
      access_valid = acc_mask[a];
      if (a == stall_age) begin
        bin_ready = 1'b0;
        repeat (3) begin
          check_rec(a);
          cyc();
        end
        bin_ready = 1'b1;
      end
      check_rec(a);
      cyc();
    end
    access_valid = 1'b0;
    chk("done_busy", busy, 1'b1);
    chk("done_bin_valid", bin_valid, 1'b0);
  endtask

  task automatic finish_idle();
    cyc();
    chk("idle_busy", busy, 1'b0);
    chk("idle_update_EVA", update_EVA, 1'b0);
  endtask

  initial begin
    rst          = 1'b0;
    access_valid = 1'b0;
    bin_ready    = 1'b1;
    interval     = '0;
    set_inputs(0);
    repeat (2) @(negedge clk);
    chk("rst_update_EVA", update_EVA, 1'b0);
    chk("rst_bin_valid", bin_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_bin_age", bin_age, N - 1);
    chk("rst_hits_R", bin_hits_R, 0);
    rst = 1'b1;

    // interval 0 never triggers
    access_valid = 1'b1;
    repeat (3) cyc();
    access_valid = 1'b0;
    chk("interval0_busy", busy, 1'b0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;

    // first epoch, then stalled epoch with inputs changing during SCAN
    interval = 13'd4;
    start_epoch(4);
    run_scan(-1, '0, 1'b0);
    finish_idle();
    set_inputs(1);
    start_epoch(4);
    run_scan(5, '0, 1'b1);
    finish_idle();
    chk("no_overrun_yet", overrun, 1'b0);

    // one trigger during SCAN -> back-to-back epoch
    interval = 13'd2;
    set_inputs(2);
    start_epoch(2);
    run_scan(-1, 8'b0110_0000, 1'b0);
    chk("pending_no_overrun", overrun, 1'b0);
    cyc();
    chk("b2b_update_EVA", update_EVA, 1'b1);
    chk("b2b_busy", busy, 1'b1);
    run_scan(-1, '0, 1'b0);
    finish_idle();
    chk("b2b_overrun", overrun, 1'b0);

    // two triggers during stalled SCAN -> overrun, single extra epoch
    set_inputs(3);
    start_epoch(2);
    run_scan(5, 8'b0010_0000, 1'b0);
    chk("overrun_set", overrun, 1'b1);
    cyc();
    chk("extra_update_EVA", update_EVA, 1'b1);
    run_scan(-1, '0, 1'b0);
    finish_idle();
    repeat (3) cyc();
    chk("no_second_extra", busy, 1'b0);
    chk("overrun_sticky", overrun, 1'b1);

    // reset mid-SCAN
    interval = 13'd4;
    set_inputs(4);
    start_epoch(4);
    cyc();
    check_rec(7);
    cyc();
    check_rec(6);
    rst = 1'b0;
    #1;
    chk("mid_rst_bin_valid", bin_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_update", update_EVA, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
    chk("mid_rst_age", bin_age, N - 1);
    chk("mid_rst_hits_R", bin_hits_R, 0);
    chk("mid_rst_last", bin_last, 1'b0);
    repeat (2) begin
      cyc();
      chk("rst_hold_update", update_EVA, 1'b0);
      chk("rst_hold_valid", bin_valid, 1'b0);
    end
    rst = 1'b1;
    cyc();
    chk("post_rst_idle", busy, 1'b0);
    set_inputs(5);
    start_epoch(4);
    run_scan(-1, '0, 1'b0);
    finish_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eva_update_ctrl.md
EVA_UPDATE_CTRL -- requirements
Module: eva_update_ctrl

Interface
REQ-001 SHALL have parameter K, default 3: age counter width.
REQ-002 SHALL have parameter N, default 2**K: number of age bins.
REQ-003 SHALL have parameter CTR_LEN, default 10: per-bin counter width.
REQ-004 SHALL have parameter ACC_W, default 13: access interval counter width.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port access_valid, input, 1: one cache access this cycle.
REQ-008 SHALL have port interval, input, ACC_W: accesses per EVA epoch; 0 disables epochs.
REQ-009 SHALL have port hitCtr_R_1D, input, CTR_LEN*N: reused-class hit counters; bin w at [w*CTR_LEN +: CTR_LEN].
REQ-010 SHALL have port hitCtr_NR_1D, input, CTR_LEN*N: non-reused-class hit counters, same packing.
REQ-011 SHALL have port evictCtr_1D, input, CTR_LEN*N: eviction counters, same packing.
REQ-012 SHALL have port update_EVA, output, 1: one-cycle pulse that clears the counter blocks.
REQ-013 SHALL have port bin_valid, output, 1: a bin record is presented.
REQ-014 SHALL have port bin_ready, input, 1: the consumer accepts the record.
REQ-015 SHALL have port bin_age, output, K: age index of the presented record.
REQ-016 SHALL have ports bin_hits_R, bin_hits_NR and bin_evicts, output, CTR_LEN each: snapshot values for bin_age.
REQ-017 SHALL have port bin_last, output, 1: marks the record with bin_age==0.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-019 SHALL have port overrun, output, 1: sticky flag for a lost epoch.

Function
REQ-020 FSM states SHALL be IDLE, SNAP, SCAN and DONE.
REQ-021 acc_cnt (ACC_W bits) SHALL increment on access_valid in every state.
- When access_valid && acc_cnt==interval-1 && interval!=0: acc_cnt wraps to 0 and a trigger fires.
REQ-022 A trigger in IDLE SHALL move the FSM to SNAP on the next edge.
REQ-023 The SNAP cycle SHALL:
- copy all three counter vectors into shadow registers;
- assert update_EVA for exactly this cycle;
- load bin index N-1;
- move to SCAN.
REQ-024 In SCAN:
- bin_valid=1, bin_age=index, and data taken from the shadow registers at that index;
- bin_last=(index==0).
REQ-025 A record SHALL transfer only on bin_valid && bin_ready; outputs stay stable while bin_ready is low.
REQ-026 On transfer, index SHALL decrement; a transfer with bin_last moves the FSM to DONE.
REQ-027 DONE SHALL last one cycle.
- If pending is set: clear pending and go to SNAP.
- Otherwise go to IDLE.
REQ-028 A trigger in SNAP, SCAN or DONE SHALL set pending.
REQ-029 A trigger while pending is already set SHALL set overrun; overrun is cleared only by reset.
REQ-030 A trigger in DONE with pending clear SHALL set pending, so that DONE proceeds to SNAP.
REQ-031 Changing interval mid-epoch SHALL take effect at the next compare.
- If acc_cnt is already at or above the new interval, it counts up to wrap at 2**ACC_W before comparing again.
REQ-032 Counter values SHALL pass through unmodified; no arithmetic is applied beyond snapshotting.

Reset
REQ-033 While rst is low, the following SHALL be forced immediately:
- state=IDLE, acc_cnt=0, index=N-1;
- pending=0, overrun=0, all shadow registers 0;
- update_EVA=0, bin_valid=0, busy=0.
REQ-034 A reset asserted mid-SCAN SHALL abandon the epoch with no further records and no update_EVA pulse.

Structure
REQ-035 The FSM state encoding and the default values of K, CTR_LEN and ACC_W SHALL live in a shared EVA package used by hit_ctr and the eviction counter.
REQ-036 The shadow store SHALL be one sub-module, eva_snap_buf: an N-entry, 3-field register file with a single-cycle parallel load and an indexed read.

Verification
REQ-037 The bench SHALL cover: interval=4, 4 accesses in IDLE -> SNAP on the next edge, a one-cycle update_EVA, busy high.
REQ-038 The bench SHALL cover: bin 3 hitCtr_R=5, bin 0 evictCtr=7, bin_ready held 1 -> 8 records over 8 consecutive cycles, ages 7..0, bin 3 reports hits_R=5, bin 0 reports evicts=7 with bin_last=1.
REQ-039 The bench SHALL cover: bin_ready low for 3 cycles at age 5 -> bin_age and data held constant, no record skipped.
REQ-040 The bench SHALL cover: interval=2, 2 accesses during SCAN -> pending set; after DONE a second SNAP runs with no intermediate IDLE, overrun stays 0.
REQ-041 The bench SHALL cover: interval=2, 4 accesses during a stalled SCAN -> overrun=1, exactly one extra epoch runs.
REQ-042 The bench SHALL cover: rst low mid-SCAN -> all outputs reset at once, no update_EVA; after release, 4 accesses at interval=4 start a fresh epoch.
